// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch stage: FSM states, reset PC, next-PC select codes.
package pc_fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_PLUS4  = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } next_sel_t;

endpackage

// File: rtl/pc_fetch_next_sel.sv
// Next-PC priority mux (jump > branch > pc+4) with word alignment; purely combinational.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  next_sel_t   sel;
  logic [31:0] raw_pc;

  always_comb begin
    sel = SEL_PLUS4;
    if (jump) begin
      sel = SEL_JUMP;
    end else if (branch_taken) begin
      sel = SEL_BRANCH;
    end
  end

  always_comb begin
    raw_pc = pc_plus4;
    case (sel)
      SEL_JUMP:   raw_pc = jump_target;
      SEL_BRANCH: raw_pc = branch_target;
      default:    raw_pc = pc_plus4;
    endcase
    next_pc = raw_pc & ~32'h0000_0003;
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register + two-state fetch FSM; instr valid the cycle after imem_ack, held while stall=1.
// Optional PC_FETCH_COUNT_EN adds fetch_count, bumped on every HOLD->FETCH transition.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  next_pc;

  pc_next_sel u_next_sel (
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc)
  );

  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = HOLD;
      end
      HOLD: begin
        if (!stall) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Reset wins over a coinciding ack so the returned word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
`ifdef PC_FETCH_COUNT_EN
      fetch_count <= 32'h0;
`endif
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (state == HOLD && !stall) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
`ifdef PC_FETCH_COUNT_EN
        fetch_count <= fetch_count + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes {pc, word} expectations, a monitor checks each new instr.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
`ifdef PC_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  // External PC+4 adder.
  assign pc_plus4 = pc + 32'd4;

  pc_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid)
`ifdef PC_FETCH_COUNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every newly valid instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr %h with empty queue", instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.word);
        chk("sb_pc", pc, e.pc);
      end
    end
    prev_valid = instr_valid;
  end

  // Called at a negedge while in FETCH; returns at the negedge after HOLD is entered.
  task automatic fetch(input int dly, input logic [31:0] exp_pc, input logic [31:0] word,
                       input logic br_pulse);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < dly; i++) begin
      if (br_pulse && i == 0) begin
        branch_taken  = 1'b1;
        branch_target = 32'h0000_5000;
      end
      @(negedge clk);
      branch_taken = 1'b0;
      chk("fetch_wait_pc", pc, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back('{pc: exp_pc, word: word});
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  // Called at the negedge just after HOLD entry; stalls, then exits with the given redirect.
  task automatic hold_exit(input int stall_cyc, input logic j, input logic [31:0] jt,
                           input logic b, input logic [31:0] bt, input logic [31:0] exp_next);
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    held_pc    = pc;
    held_instr = instr;
    jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    stall = (stall_cyc > 0);
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc", pc, held_pc);
      chk("stall_instr", instr, held_instr);
    end
    stall = 1'b0;
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0;
    chk("exit_pc", pc, exp_next);
    chk("exit_valid", {31'b0, instr_valid}, 32'd0);
    chk("exit_req", {31'b0, imem_req}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = 32'h0; branch_target = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0000_0100);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
`ifdef PC_FETCH_COUNT_EN
    chk("rst_count", fetch_count, 32'd0);
`endif
    rst = 1'b0;

    fetch(2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    hold_exit(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0104);
    fetch(0, 32'h0000_0104, 32'h1111_1111, 1'b0);
    hold_exit(5, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0108);
    fetch(1, 32'h0000_0108, 32'h2222_2222, 1'b0);
    hold_exit(0, 1'b1, 32'h0000_2000, 1'b1, 32'h0000_3000, 32'h0000_2000);
`ifdef PC_FETCH_COUNT_EN
    chk("count_3", fetch_count, 32'd3);
`endif
    fetch(0, 32'h0000_2000, 32'h3333_3333, 1'b0);
    hold_exit(0, 1'b0, 32'h0, 1'b1, 32'h0000_3003, 32'h0000_3000);
    fetch(0, 32'h0000_3000, 32'h4444_4444, 1'b0);
    hold_exit(2, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'hFFFF_FFFC);
    fetch(3, 32'hFFFF_FFFC, 32'h5555_5555, 1'b1);
    hold_exit(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000);
    fetch(0, 32'h0000_0000, 32'h6666_6666, 1'b0);
    hold_exit(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0004);

    // Reset coinciding with an ack: word must be dropped.
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777; rst = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; rst = 1'b0;
    chk("rack_pc", pc, 32'h0000_0100);
    chk("rack_valid", {31'b0, instr_valid}, 32'd0);
    chk("rack_instr", instr, 32'h0);
    @(negedge clk);
    chk("rack_req", {31'b0, imem_req}, 32'd1);
    chk("rack_valid2", {31'b0, instr_valid}, 32'd0);
`ifdef PC_FETCH_COUNT_EN
    chk("rack_count", fetch_count, 32'd0);
`endif

    fetch(1, 32'h0000_0100, 32'h8888_8888, 1'b0);
    hold_exit(0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0104);
    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 pc  out  32  current program counter, driving the PC+4 adder input and imem_addr.
REQ-005 pc_plus4  in  32  PC+4 adder result, pc + 4 modulo 2^32.
REQ-006 branch_taken  in  1  conditional redirect request.
REQ-007 branch_target  in  32  branch destination.
REQ-008 jump  in  1  unconditional redirect request.
REQ-009 jump_target  in  32  jump destination.
REQ-010 stall  in  1  downstream not ready to consume instr.
REQ-011 imem_req  out  1  instruction memory read request.
REQ-012 imem_addr  out  32  read address, equal to pc.
REQ-013 imem_ack  in  1  read data valid this cycle.
REQ-014 imem_rdata  in  32  fetched word.
REQ-015 instr  out  32  registered instruction.
REQ-016 instr_valid  out  1  instr holds a valid word for the current pc.

Function
REQ-017 The FSM SHALL have exactly two states: FETCH and HOLD.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the block SHALL stay in FETCH while imem_ack=0.
REQ-019 In FETCH with imem_ack=1, the block SHALL register instr<=imem_rdata, set instr_valid<=1 and go to HOLD; latency is ack cycle + 1.
REQ-020 In HOLD, imem_req SHALL be 0 and instr/instr_valid SHALL stay stable while stall=1.
REQ-021 In HOLD with stall=0, the block SHALL load pc with the next PC, clear instr_valid and return to FETCH in the same edge.
REQ-022 Next PC priority SHALL be jump_target if jump=1, else branch_target if branch_taken=1, else pc_plus4.
REQ-023 Redirect and stall inputs SHALL be ignored in FETCH; they are sampled only in HOLD.
REQ-024 Bits [1:0] of the selected next PC SHALL be forced to 2'b00 (word alignment).
REQ-025 pc 32'hFFFF_FFFC with no redirect SHALL wrap to 32'h0000_0000, with no error indication.
REQ-026 pc SHALL change only per REQ-021 or on reset.

Reset
REQ-027 With rst=1 at a clock edge: pc<=RESET_PC, state<=FETCH, instr<=0, instr_valid<=0, regardless of state or a concurrent imem_ack.
REQ-028 An ack coinciding with reset SHALL be discarded; instruction memory SHALL share the same rst.

Configuration
REQ-029 Macro PC_FETCH_COUNT_EN: when defined, the block SHALL add output fetch_count[31:0], cleared on reset and incremented by 1 at each HOLD->FETCH transition, wrapping at 2^32.
REQ-030 Without PC_FETCH_COUNT_EN, port fetch_count and its counter SHALL NOT exist; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (FETCH, HOLD), the default RESET_PC constant and the next-PC select encoding (SEL_PLUS4, SEL_BRANCH, SEL_JUMP).
REQ-032 The next-PC priority mux with alignment forcing SHALL be one combinational sub-module, pc_next_sel; all registers SHALL reside in pc_fetch.

Verification
REQ-033 Reset, RESET_PC=0x100, ack 2 cycles after request with rdata 0xDEADBEEF, stall=0 -> instr=0xDEADBEEF and instr_valid=1 on the cycle after ack, then pc=0x104.
REQ-034 In HOLD, stall=1 for 5 cycles -> instr, instr_valid=1 and pc unchanged, imem_req=0; stall released -> pc advances by 4 on the next edge.
REQ-035 In HOLD, jump=1 with jump_target=0x2000 and branch_taken=1 with branch_target=0x3000 -> pc=0x2000; branch_target=0x3003 alone -> pc=0x3000.
REQ-036 pc=0xFFFFFFFC, no redirect -> pc=0x00000000 after HOLD exit; branch_taken pulsed during FETCH -> ignored.
REQ-037 rst asserted in the same cycle as imem_ack -> pc=RESET_PC, instr_valid=0, state FETCH, ack data dropped.
REQ-038 With PC_FETCH_COUNT_EN, 3 completed fetches -> fetch_count=3; count=0 after reset.
